median_partition_reader: RTL and testbench
==========================================

// Module: median_partition_reader
// PURPOSE
// - Consumer end of the fill_and_check token interface: pops the five FWFT FIFO
//   streams (px, pivot, buff_size, median_pos, second_median_value) written by
//   the first median stage.
// - Counts buffer pixels below and equal to the pivot, classifies where the
//   median lies, and pushes one result word per buffer to a downstream FIFO.
// - Sits between the fill/check stage and the median controller that picks the
//   next pivot.
// PARAMETERS
// - BUFF_SIZE      1024  maximum pixels per buffer (for bench bounds only)
// - BUFF_SIZE_BIT  16    width of buff_size, median_pos and the counters
// PORTS
// - clock                        in   1    system clock, rising edge
// - reset                        in   1    synchronous, active-low reset
// - in_px                        in   8    pixel, valid while !in_px_empty
// - in_px_rd                     out  1    pop in_px
// - in_px_empty                  in   1    px FIFO empty
// - in_pivot                     in   8    pivot token
// - in_pivot_rd / _empty         out/in 1  pop / empty
// - in_buff_size                 in   BSB  number of pixels that follow
// - in_buff_size_rd / _empty     out/in 1  pop / empty
// - in_median_pos                in   BSB  0-based rank of the median in the buffer
// - in_median_pos_rd / _empty    out/in 1  pop / empty
// - in_second_median_value       in   8    partner value for even-size buffers
// - in_second_median_value_rd / _empty  out/in 1  pop / empty
// - out_region                   out  2    0=LOW 1=FOUND 2=HIGH 3=ERR
// - out_cnt_lt                   out  BSB  pixels < pivot
// - out_cnt_eq                   out  BSB  pixels == pivot
// - out_median                   out  8    median value (valid when region==FOUND)
// - out_result_wr                out  1    push result word
// - out_result_full              in   1    result FIFO full
// BEHAVIOUR
// - Pop beat is x_rd & !x_empty. Every *_rd is combinational from state and
//   never asserted while the matching *_empty is high.
// - FSM IDLE -> LOAD -> COUNT -> DECIDE -> OUT -> IDLE.
// - IDLE: when all four header FIFOs are non-empty, pop all four in the same
//   cycle. Latch pivot, size, pos and second value. Clear cnt_lt, cnt_eq and
//   the pixel counter. Go to LOAD.
// - LOAD (1 cycle): if size==0, go to DECIDE with the ERR flag set; else go to
//   COUNT.
// - COUNT: in_px_rd = !in_px_empty. Per beat, cnt_lt += (px<pivot) and
//   cnt_eq += (px==pivot), compared unsigned. When pixel_cnt reaches size-1
//   on a beat, go to DECIDE. Empty stalls without losing count.
// - DECIDE (1 cycle):
//   - ERR if size==0 or pos>=size.
//   - else LOW if pos<cnt_lt.
//   - else FOUND if pos<cnt_lt+cnt_eq (the sum is BSB+1 bits wide, no wrap).
//   - else HIGH.
//   - out_median = pivot.
// - OUT: out_result_wr = !out_result_full. Outputs hold stable until accepted,
//   then return to IDLE. Minimum latency from the last pixel pop to the push is
//   2 cycles.
// - Reset values: all *_rd=0, out_result_wr=0, out_region=0, out_cnt_lt=0,
//   out_cnt_eq=0, out_median=0, state=IDLE.
// - Reset mid-buffer: return to IDLE immediately. Counters clear, no further
//   pops. Already-popped tokens are lost; flushing them is upstream's job.
// - Header FIFOs are never popped outside IDLE. The px FIFO is never popped
//   outside COUNT.
// CONFIGURATION
// - MEDIAN_AVG_EN defined: in DECIDE, if size is even and region is FOUND with
//   pos==cnt_lt+cnt_eq-1, out_median = (pivot+second_median_value+1)>>1,
//   computed as a 9-bit sum.
// - MEDIAN_AVG_EN undefined: out_median = pivot always, and the latched
//   second_median_value is popped but unused.
// TESTING
// - pivot=127, size=4, pos=1, px {10,200,127,127}
//   -> lt=1, eq=2, region=FOUND, median=127.
// - pivot=127, size=4, pos=2, px {1,2,3,200}
//   -> lt=3, eq=0, region=LOW.
// - pivot=127, size=4, pos=1, px {200,201,202,5}
//   -> lt=1, eq=0, region=HIGH.
// - size=0 (and separately pos=5 with size=4)
//   -> no px pops, region=ERR, one result push.
// - px FIFO empty for 3 cycles mid-buffer and out_result_full held 4 cycles
//   -> counts unchanged, outputs stable, exactly one push.
// - reset low during COUNT after 2 of 4 pixels
//   -> next cycle IDLE, all outputs 0, no rd asserted until new headers arrive.
// - MEDIAN_AVG_EN: size=4, pivot=100, second=103, pos=2, px {1,100,100,200}
//   -> median=102.

Source files
------------

// File: rtl/median_partition_reader.sv
// median_partition_reader
//   Consumer end of the fill_and_check token interface. Pops one header
//   (pivot, buff_size, median_pos, second_median_value) from four FWFT FIFOs,
//   then pops buff_size pixels. It counts the pixels below and equal to the
//   pivot, classifies where the median rank falls, and pushes one result word
//   to the downstream FIFO.
//
// Optional feature: define MEDIAN_AVG_EN to enable median averaging. When an
//   even-size buffer has its median rank at the top of the pivot-equal run,
//   out_median becomes round-half-up((pivot + second_median_value) / 2).
//   When the macro is undefined, out_median is always the pivot.
//
// Ports
//   clock, reset               rising-edge clock, synchronous active-low reset
//   in_px / _rd / _empty       pixel stream
//   in_pivot / _rd / _empty    pivot token
//   in_buff_size / ...         pixel count of the buffer
//   in_median_pos / ...        0-based median rank
//   in_second_median_value/... partner value for even-size buffers
//   out_region                 0=LOW 1=FOUND 2=HIGH 3=ERR
//   out_cnt_lt, out_cnt_eq     pixels below / equal to the pivot
//   out_median                 median value (meaningful when FOUND)
//   out_result_wr / _full      result push / downstream full
module median_partition_reader #(
  parameter int unsigned BUFF_SIZE_BIT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  input  logic [7:0]               in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [7:0]               in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,
  output logic [1:0]               out_region,
  output logic [BUFF_SIZE_BIT-1:0] out_cnt_lt,
  output logic [BUFF_SIZE_BIT-1:0] out_cnt_eq,
  output logic [7:0]               out_median,
  output logic                     out_result_wr,
  input  logic                     out_result_full
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COUNT, S_DECIDE, S_OUT} state_e;
  typedef enum logic [1:0] {
    R_LOW   = 2'd0,
    R_FOUND = 2'd1,
    R_HIGH  = 2'd2,
    R_ERR   = 2'd3
  } region_e;

  localparam logic [BUFF_SIZE_BIT-1:0] ONE = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  region_e                  region_q, region_d;
  logic [7:0]               pivot_q, pivot_d;
  logic [7:0]               median_q, median_d;
  logic [BUFF_SIZE_BIT-1:0] size_q, size_d;
  logic [BUFF_SIZE_BIT-1:0] pos_q, pos_d;
  logic [BUFF_SIZE_BIT-1:0] lt_q, lt_d;
  logic [BUFF_SIZE_BIT-1:0] eq_q, eq_d;
  logic [BUFF_SIZE_BIT-1:0] pix_q, pix_d;
  logic                     hdr_rd, px_rd, res_wr;
  logic                     hdr_avail;
  // One bit wider than the counters so lt+eq never wraps.
  logic [BUFF_SIZE_BIT:0]   lt_plus_eq;

`ifdef MEDIAN_AVG_EN
  logic [7:0] second_q, second_d;
  logic [8:0] avg_sum;
  assign avg_sum = {1'b0, pivot_q} + {1'b0, second_q} + 9'd1;
`else
  // The partner value is still popped to keep the streams aligned.
  logic unused_second_value;
  assign unused_second_value = ^in_second_median_value;
`endif

  // Pops are gated by reset so nothing is consumed while reset is held.
  assign hdr_avail  = reset & ~in_pivot_empty & ~in_buff_size_empty &
                      ~in_median_pos_empty & ~in_second_median_value_empty;
  assign lt_plus_eq = {1'b0, lt_q} + {1'b0, eq_q};

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    pivot_d  = pivot_q;
    median_d = median_q;
    size_d   = size_q;
    pos_d    = pos_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    pix_d    = pix_q;
`ifdef MEDIAN_AVG_EN
    second_d = second_q;
`endif
    hdr_rd   = 1'b0;
    px_rd    = 1'b0;
    res_wr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hdr_avail) begin
          hdr_rd  = 1'b1;
          pivot_d = in_pivot;
          size_d  = in_buff_size;
          pos_d   = in_median_pos;
`ifdef MEDIAN_AVG_EN
          second_d = in_second_median_value;
`endif
          lt_d    = '0;
          eq_d    = '0;
          pix_d   = '0;
          state_d = S_LOAD;
        end
      end
      // An empty buffer skips counting; DECIDE flags it as ERR.
      S_LOAD: state_d = (size_q == '0) ? S_DECIDE : S_COUNT;
      S_COUNT: begin
        px_rd = reset & ~in_px_empty;
        if (px_rd) begin
          if (in_px < pivot_q)  lt_d = lt_q + ONE;
          if (in_px == pivot_q) eq_d = eq_q + ONE;
          if (pix_q == size_q - ONE) state_d = S_DECIDE;
          else                       pix_d   = pix_q + ONE;
        end
      end
      S_DECIDE: begin
        median_d = pivot_q;
        if (size_q == '0 || pos_q >= size_q) region_d = R_ERR;
        else if (pos_q < lt_q)               region_d = R_LOW;
        else if ({1'b0, pos_q} < lt_plus_eq) region_d = R_FOUND;
        else                                 region_d = R_HIGH;
`ifdef MEDIAN_AVG_EN
        // Rank at the top of the equal run: the partner lies just above it.
        if (!size_q[0] && region_d == R_FOUND &&
            {1'b0, pos_q} == lt_plus_eq - {{BUFF_SIZE_BIT{1'b0}}, 1'b1})
          median_d = avg_sum[8:1];
`endif
        state_d = S_OUT;
      end
      S_OUT: begin
        res_wr = reset & ~out_result_full;
        if (res_wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      region_q <= R_LOW;
      pivot_q  <= '0;
      median_q <= '0;
      size_q   <= '0;
      pos_q    <= '0;
      lt_q     <= '0;
      eq_q     <= '0;
      pix_q    <= '0;
`ifdef MEDIAN_AVG_EN
      second_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      pivot_q  <= pivot_d;
      median_q <= median_d;
      size_q   <= size_d;
      pos_q    <= pos_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      pix_q    <= pix_d;
`ifdef MEDIAN_AVG_EN
      second_q <= second_d;
`endif
    end
  end

  assign in_px_rd                  = px_rd;
  assign in_pivot_rd               = hdr_rd;
  assign in_buff_size_rd           = hdr_rd;
  assign in_median_pos_rd          = hdr_rd;
  assign in_second_median_value_rd = hdr_rd;
  assign out_result_wr             = res_wr;
  assign out_region                = region_q;
  assign out_cnt_lt                = lt_q;
  assign out_cnt_eq                = eq_q;
  assign out_median                = median_q;

endmodule

// File: tb/tb_median_partition_reader.sv
module tb_median_partition_reader;
  localparam int unsigned BSB       = 16;
  localparam int unsigned BUFF_SIZE = 1024;
`ifdef MEDIAN_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  typedef logic [7:0] pxq_t[$];
  typedef struct packed {
    logic [1:0]     region;
    logic [BSB-1:0] lt;
    logic [BSB-1:0] eq;
    logic [7:0]     med;
  } res_t;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     in_px = '0;
  logic           in_px_rd;
  logic           in_px_empty = 1'b1;
  logic [7:0]     in_pivot = '0;
  logic           in_pivot_rd;
  logic           in_pivot_empty = 1'b1;
  logic [BSB-1:0] in_buff_size = '0;
  logic           in_buff_size_rd;
  logic           in_buff_size_empty = 1'b1;
  logic [BSB-1:0] in_median_pos = '0;
  logic           in_median_pos_rd;
  logic           in_median_pos_empty = 1'b1;
  logic [7:0]     in_second_median_value = '0;
  logic           in_second_median_value_rd;
  logic           in_second_median_value_empty = 1'b1;
  logic [1:0]     out_region;
  logic [BSB-1:0] out_cnt_lt;
  logic [BSB-1:0] out_cnt_eq;
  logic [7:0]     out_median;
  logic           out_result_wr;
  logic           out_result_full = 1'b0;

  logic [7:0]     px_f[$], piv_f[$], sec_f[$];
  logic [BSB-1:0] size_f[$], pos_f[$];
  res_t           exp_q[$], got_q[$];
  int unsigned    px_pops = 0, hdr_pops = 0, push_cnt = 0, viol = 0;
  bit             px_stall = 1'b0, res_full = 1'b0;
  int             n_checks = 0, n_pass = 0;

  always #5 clock = ~clock;

  median_partition_reader #(.BUFF_SIZE_BIT(BSB)) dut (
    .clock(clock), .reset(reset),
    .in_px(in_px), .in_px_rd(in_px_rd), .in_px_empty(in_px_empty),
    .in_pivot(in_pivot), .in_pivot_rd(in_pivot_rd), .in_pivot_empty(in_pivot_empty),
    .in_buff_size(in_buff_size), .in_buff_size_rd(in_buff_size_rd),
    .in_buff_size_empty(in_buff_size_empty),
    .in_median_pos(in_median_pos), .in_median_pos_rd(in_median_pos_rd),
    .in_median_pos_empty(in_median_pos_empty),
    .in_second_median_value(in_second_median_value),
    .in_second_median_value_rd(in_second_median_value_rd),
    .in_second_median_value_empty(in_second_median_value_empty),
    .out_region(out_region), .out_cnt_lt(out_cnt_lt), .out_cnt_eq(out_cnt_eq),
    .out_median(out_median), .out_result_wr(out_result_wr),
    .out_result_full(out_result_full)
  );

  // FIFO models: pop on the edge where rd & !empty (pre-edge values).
  always @(posedge clock) begin
    if (in_px_rd && !in_px_empty) begin void'(px_f.pop_front()); px_pops++; end
    if (in_pivot_rd && !in_pivot_empty) begin void'(piv_f.pop_front()); hdr_pops++; end
    if (in_buff_size_rd && !in_buff_size_empty) void'(size_f.pop_front());
    if (in_median_pos_rd && !in_median_pos_empty) void'(pos_f.pop_front());
    if (in_second_median_value_rd && !in_second_median_value_empty) void'(sec_f.pop_front());
  end

  // Inputs refresh after the falling edge; then the result/protocol monitor.
  always @(negedge clock) begin
    #1;
    in_px_empty                  = px_stall || px_f.size() == 0;
    in_px                        = (px_f.size() != 0) ? px_f[0] : 8'h00;
    in_pivot_empty               = piv_f.size() == 0;
    in_pivot                     = (piv_f.size() != 0) ? piv_f[0] : 8'h00;
    in_buff_size_empty           = size_f.size() == 0;
    in_buff_size                 = (size_f.size() != 0) ? size_f[0] : '0;
    in_median_pos_empty          = pos_f.size() == 0;
    in_median_pos                = (pos_f.size() != 0) ? pos_f[0] : '0;
    in_second_median_value_empty = sec_f.size() == 0;
    in_second_median_value       = (sec_f.size() != 0) ? sec_f[0] : 8'h00;
    out_result_full              = res_full;
    #1;
    if (out_result_wr && !out_result_full) begin
      got_q.push_back('{region: out_region, lt: out_cnt_lt, eq: out_cnt_eq, med: out_median});
      push_cnt++;
    end
    if ((in_px_rd && in_px_empty) || (in_pivot_rd && in_pivot_empty) ||
        (in_buff_size_rd && in_buff_size_empty) || (in_median_pos_rd && in_median_pos_empty) ||
        (in_second_median_value_rd && in_second_median_value_empty) ||
        (out_result_wr && out_result_full))
      viol++;
  end

  function automatic pxq_t mk4(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    pxq_t q;
    q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
    return q;
  endfunction

  function automatic res_t model(input logic [7:0] piv, input int size, input int pos,
                                 input logic [7:0] sec, input pxq_t pxs);
    int   lt = 0, eq = 0, s;
    res_t r;
    foreach (pxs[i]) begin
      if (pxs[i] < piv) lt++;
      else if (pxs[i] == piv) eq++;
    end
    r.lt  = lt[BSB-1:0];
    r.eq  = eq[BSB-1:0];
    r.med = piv;
    if (size == 0 || pos >= size) r.region = 2'd3;
    else if (pos < lt)            r.region = 2'd0;
    else if (pos < lt + eq)       r.region = 2'd1;
    else                          r.region = 2'd2;
    s = int'(piv) + int'(sec) + 1;
    if (AVG && (size % 2 == 0) && r.region == 2'd1 && pos == lt + eq - 1) r.med = s[8:1];
    return r;
  endfunction

  task automatic send(input logic [7:0] piv, input logic [BSB-1:0] size,
                      input logic [BSB-1:0] pos, input logic [7:0] sec,
                      input pxq_t pxs, input res_t exp);
    piv_f.push_back(piv); size_f.push_back(size); pos_f.push_back(pos); sec_f.push_back(sec);
    foreach (pxs[i]) px_f.push_back(pxs[i]);
    exp_q.push_back(exp);
  endtask

  task automatic collect(output res_t got, output res_t exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(BUFF_SIZE) && !ok; i++) begin
      @(negedge clock);
      if (got_q.size() != 0) ok = 1'b1;
    end
    got = ok ? got_q.pop_front() : '0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; res_full = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({out_region, out_cnt_lt, out_cnt_eq, out_median} !== '0)
      $display("FAIL reset_outputs: got region=%0d lt=%0d eq=%0d med=%0d, expected all 0",
               out_region, out_cnt_lt, out_cnt_eq, out_median);
    else n_pass++;
    n_checks++;
    if ({in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
         in_second_median_value_rd, out_result_wr} !== 6'b0)
      $display("FAIL reset_strobes: got %b, expected 000000",
               {in_px_rd, in_pivot_rd, in_buff_size_rd, in_median_pos_rd,
                in_second_median_value_rd, out_result_wr});
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_vector(input string name, input logic [7:0] piv,
                             input logic [BSB-1:0] pos, input logic [7:0] sec,
                             input pxq_t pxs, input res_t exp_c);
    res_t got, exp; bit ok;
    send(piv, BSB'(pxs.size()), pos, sec, pxs, exp_c);
    collect(got, exp, ok);
    n_checks++;
    if (!ok) $display("FAIL %s: no result push within %0d cycles", name, BUFF_SIZE);
    else if (got !== exp)
      $display("FAIL %s: got region=%0d lt=%0d eq=%0d med=%0d, expected region=%0d lt=%0d eq=%0d med=%0d",
               name, got.region, got.lt, got.eq, got.med, exp.region, exp.lt, exp.eq, exp.med);
    else n_pass++;
  endtask

  task automatic test_err();
    res_t got, exp; bit ok; pxq_t none; int unsigned p0;
    p0 = px_pops;
    send(8'd127, 16'd0, 16'd0, 8'd0, none, '{region: 2'd3, lt: 16'd0, eq: 16'd0, med: 8'd127});
    send(8'd127, 16'd4, 16'd5, 8'd0, mk4(8'd10, 8'd200, 8'd127, 8'd127),
         '{region: 2'd3, lt: 16'd1, eq: 16'd2, med: 8'd127});
    collect(got, exp, ok);
    n_checks++;
    if (!ok || got !== exp)
      $display("FAIL err_size0: ok=%0d got region=%0d lt=%0d eq=%0d, expected region=3 lt=0 eq=0",
               ok, got.region, got.lt, got.eq);
    else n_pass++;
    n_checks++;
    if (px_pops !== p0) $display("FAIL err_size0_pops: got %0d px pops, expected 0", px_pops - p0);
    else n_pass++;
    collect(got, exp, ok);
    n_checks++;
    if (!ok || got !== exp)
      $display("FAIL err_pos: ok=%0d got region=%0d lt=%0d eq=%0d, expected region=3 lt=1 eq=2",
               ok, got.region, got.lt, got.eq);
    else n_pass++;
    n_checks++;
    if (px_pops !== p0 + 4) $display("FAIL err_pos_pops: got %0d px pops, expected 4", px_pops - p0);
    else n_pass++;
  endtask

  task automatic test_stall();
    res_t got, exp; bit ok, stable; int unsigned p0, pc0;
    p0 = px_pops; pc0 = push_cnt; res_full = 1'b1;
    send(8'd127, 16'd4, 16'd1, 8'd0, mk4(8'd10, 8'd200, 8'd127, 8'd127),
         '{region: 2'd1, lt: 16'd1, eq: 16'd2, med: 8'd127});
    for (int i = 0; i < 100 && px_pops < p0 + 2; i++) @(negedge clock);
    n_checks++;
    if (px_pops !== p0 + 2) $display("FAIL stall_reach: got %0d px pops, expected 2", px_pops - p0);
    else n_pass++;
    px_stall = 1'b1;
    stable = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (out_cnt_lt !== 16'd1 || out_cnt_eq !== 16'd0 || px_pops !== p0 + 2) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL stall_counts: got lt=%0d eq=%0d pops=%0d, expected lt=1 eq=0 pops=2",
                          out_cnt_lt, out_cnt_eq, px_pops - p0);
    else n_pass++;
    px_stall = 1'b0;
    for (int i = 0; i < 100 && px_pops < p0 + 4; i++) @(negedge clock);
    @(negedge clock);
    stable = 1'b1;
    repeat (4) begin
      if ({out_region, out_cnt_lt, out_cnt_eq, out_median} !== {2'd1, 16'd1, 16'd2, 8'd127} ||
          push_cnt !== pc0) stable = 1'b0;
      @(negedge clock);
    end
    n_checks++;
    if (!stable) $display("FAIL full_hold: got region=%0d lt=%0d eq=%0d med=%0d pushes=%0d, expected 1/1/2/127 pushes=0",
                          out_region, out_cnt_lt, out_cnt_eq, out_median, push_cnt - pc0);
    else n_pass++;
    res_full = 1'b0;
    collect(got, exp, ok);
    n_checks++;
    if (!ok || got !== exp)
      $display("FAIL stall_result: ok=%0d got region=%0d lt=%0d eq=%0d med=%0d, expected 1/1/2/127",
               ok, got.region, got.lt, got.eq, got.med);
    else n_pass++;
    repeat (6) @(negedge clock);
    n_checks++;
    if (push_cnt !== pc0 + 1) $display("FAIL stall_one_push: got %0d pushes, expected 1", push_cnt - pc0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int unsigned p0, h0; bit quiet;
    p0 = px_pops;
    piv_f.push_back(8'd127); size_f.push_back(16'd4); pos_f.push_back(16'd1); sec_f.push_back(8'd0);
    px_f.push_back(8'd10); px_f.push_back(8'd20); px_f.push_back(8'd30); px_f.push_back(8'd40);
    for (int i = 0; i < 100 && px_pops < p0 + 2; i++) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({out_region, out_cnt_lt, out_cnt_eq, out_median, out_result_wr, in_px_rd, in_pivot_rd} !== '0 ||
        px_pops !== p0 + 2)
      $display("FAIL reset_mid: got region=%0d lt=%0d eq=%0d med=%0d wr=%0d px_rd=%0d pops=%0d, expected zeros pops=2",
               out_region, out_cnt_lt, out_cnt_eq, out_median, out_result_wr, in_px_rd, px_pops - p0);
    else n_pass++;
    reset = 1'b1;
    h0 = hdr_pops;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (in_px_rd || in_pivot_rd || px_pops !== p0 + 2 || hdr_pops !== h0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL reset_idle: got px_pops=%0d hdr_pops=%0d, expected 2 and 0",
                         px_pops - p0, hdr_pops - h0);
    else n_pass++;
    px_f.delete();
    @(negedge clock);
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL reset_no_push: got %0d results, expected 0", got_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t got, exp; bit ok; pxq_t pxs; logic [7:0] piv, sec; int size, pos;
    for (int b = 0; b < 5; b++) begin
      size = (b == 0) ? 1 : int'($urandom_range(1, 8));
      pos  = int'($urandom_range(0, size));
      piv  = 8'($urandom_range(60, 190));
      sec  = 8'($urandom);
      pxs.delete();
      for (int i = 0; i < size; i++) pxs.push_back(($urandom_range(0, 2) == 0) ? piv : 8'($urandom));
      send(piv, BSB'(size), BSB'(pos), sec, pxs, model(piv, size, pos, sec, pxs));
    end
    for (int b = 0; b < 5; b++) begin
      collect(got, exp, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_%0d: no result push within %0d cycles", b, BUFF_SIZE);
      else if (got !== exp)
        $display("FAIL b2b_%0d: got region=%0d lt=%0d eq=%0d med=%0d, expected region=%0d lt=%0d eq=%0d med=%0d",
                 b, got.region, got.lt, got.eq, got.med, exp.region, exp.lt, exp.eq, exp.med);
      else n_pass++;
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol !== 0) $display("FAIL protocol: got %0d rd-while-empty/wr-while-full cycles, expected 0", viol);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL leftover: got %0d unmatched expectations, expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vector("found", 8'd127, 16'd1, 8'd0, mk4(8'd10, 8'd200, 8'd127, 8'd127),
                '{region: 2'd1, lt: 16'd1, eq: 16'd2, med: 8'd127});
    test_vector("low", 8'd127, 16'd2, 8'd0, mk4(8'd1, 8'd2, 8'd3, 8'd200),
                '{region: 2'd0, lt: 16'd3, eq: 16'd0, med: 8'd127});
    test_vector("high", 8'd127, 16'd1, 8'd0, mk4(8'd200, 8'd201, 8'd202, 8'd5),
                '{region: 2'd2, lt: 16'd1, eq: 16'd0, med: 8'd127});
    test_err();
    test_stall();
    test_reset_mid();
    test_vector("avg", 8'd100, 16'd2, 8'd103, mk4(8'd1, 8'd100, 8'd100, 8'd200),
                '{region: 2'd1, lt: 16'd1, eq: 16'd2, med: (AVG ? 8'd102 : 8'd100)});
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
